// File: rtl/gate_exerciser_if.sv
// Stimulus/response bundle between the gate exerciser and the environment around the gate under test.
// The master side drives the DUT vector and reports results; the slave side supplies start and dut_out.
interface gate_exerciser_if #(
  parameter int N_INPUTS = 2
);
  logic                start;
  logic                dut_out;
  logic [N_INPUTS-1:0] dut_in;
  logic                busy;
  logic                done;
  logic                pass;
  logic                result_valid;
  logic [N_INPUTS:0]   err_count;
  logic [N_INPUTS-1:0] first_fail_vec;

  modport master (
    input  start, dut_out,
    output dut_in, busy, done, pass, result_valid, err_count, first_fail_vec
  );

  modport slave (
    output start, dut_out,
    input  dut_in, busy, done, pass, result_valid, err_count, first_fail_vec
  );
endinterface

// File: rtl/gate_exerciser.sv
// Sweeps all 2**N_INPUTS vectors into a combinational gate and checks each response against
// TRUTH_TABLE; every vector costs SETTLE_CYCLES+1 cycles, start is only honoured while idle.
module gate_exerciser #(
  parameter int                        N_INPUTS      = 2,
  parameter int                        SETTLE_CYCLES = 1,
  parameter logic [(1<<N_INPUTS)-1:0]  TRUTH_TABLE   = 4'b1000
) (
  input  logic              clk,
  input  logic              reset,
  gate_exerciser_if.master  bus
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0]       SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [N_INPUTS-1:0] LAST_VEC    = '1;
  localparam logic [N_INPUTS:0]   ERR_ONE     = (N_INPUTS+1)'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [N_INPUTS-1:0] dut_in_q, dut_in_d;
  logic [SW-1:0]       settle_q, settle_d;
  logic [N_INPUTS:0]   err_q, err_d;
  logic [N_INPUTS-1:0] ffv_q, ffv_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic                rv_q, rv_d;
  logic                mismatch;

  always_comb begin
    state_d  = state_q;
    dut_in_d = dut_in_q;
    settle_d = settle_q;
    err_d    = err_q;
    ffv_d    = ffv_q;
    pass_d   = pass_q;
    rv_d     = rv_q;
    done_d   = 1'b0;
    mismatch = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          dut_in_d = '0;
          settle_d = '0;
          err_d    = '0;
          ffv_d    = '0;
          rv_d     = 1'b0;
          pass_d   = 1'b0;
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        settle_d = settle_q + SW'(1);
        if (settle_q == SETTLE_LAST) state_d = CHECK;
      end
      CHECK: begin
        mismatch = (bus.dut_out != TRUTH_TABLE[dut_in_q]);
        if (mismatch) begin
          err_d = err_q + ERR_ONE;
          if (err_q == '0) ffv_d = dut_in_q;
        end
        // Terminal detect on the all-ones vector so the counter never wraps mid-sweep
        if (dut_in_q == LAST_VEC) begin
          state_d  = DONE;
          done_d   = 1'b1;
          rv_d     = 1'b1;
          pass_d   = (err_d == '0);
          dut_in_d = '0;
        end else begin
          dut_in_d = dut_in_q + N_INPUTS'(1);
          settle_d = '0;
          state_d  = SETTLE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == SETTLE) || (state_d == CHECK);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      dut_in_q <= '0;
      settle_q <= '0;
      err_q    <= '0;
      ffv_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      rv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      dut_in_q <= dut_in_d;
      settle_q <= settle_d;
      err_q    <= err_d;
      ffv_q    <= ffv_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      rv_q     <= rv_d;
    end
  end

  assign bus.dut_in         = dut_in_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.pass           = pass_q;
  assign bus.result_valid   = rv_q;
  assign bus.err_count      = err_q;
  assign bus.first_fail_vec = ffv_q;

endmodule

// File: tb/tb_gate_exerciser.sv
// Bench for gate_exerciser: a default AND checker fed by a selectable gate model, plus an
// XOR checker with a longer settle time; sweep results are scoreboarded against a gate model.
module tb_gate_exerciser;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  int   gate_mode = 0;
  logic sel_b = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int err;
    int ffv;
    bit pass;
    int done_edge;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  function automatic logic gate_fn(input int mode, input logic [1:0] v);
    case (mode)
      0:       return v[0] & v[1];
      1:       return v[0] | v[1];
      2:       return 1'b1;
      default: return v[0] ^ v[1];
    endcase
  endfunction

  gate_exerciser_if #(.N_INPUTS(2)) if_a ();
  gate_exerciser_if #(.N_INPUTS(2)) if_b ();

  assign if_a.start   = start_a;
  assign if_b.start   = start_b;
  assign if_a.dut_out = gate_fn(gate_mode, if_a.dut_in);
  assign if_b.dut_out = gate_fn(3, if_b.dut_in);

  gate_exerciser #(.N_INPUTS(2), .SETTLE_CYCLES(1), .TRUTH_TABLE(4'b1000)) u_a (
    .clk(clk), .reset(reset), .bus(if_a)
  );
  gate_exerciser #(.N_INPUTS(2), .SETTLE_CYCLES(3), .TRUTH_TABLE(4'b0110)) u_b (
    .clk(clk), .reset(reset), .bus(if_b)
  );

  wire [1:0] dut_in_m = sel_b ? if_b.dut_in         : if_a.dut_in;
  wire       busy_m   = sel_b ? if_b.busy           : if_a.busy;
  wire       done_m   = sel_b ? if_b.done           : if_a.done;
  wire       pass_m   = sel_b ? if_b.pass           : if_a.pass;
  wire       rv_m     = sel_b ? if_b.result_valid   : if_a.result_valid;
  wire [2:0] err_m    = sel_b ? if_b.err_count      : if_a.err_count;
  wire [1:0] ffv_m    = sel_b ? if_b.first_fail_vec : if_a.first_fail_vec;

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({if_a.dut_in, if_a.busy, if_a.done, if_a.pass, if_a.result_valid,
         if_a.err_count, if_a.first_fail_vec} !== 11'd0) begin
      n_errors++;
      $display("FAIL reset_a: outputs=%b required all zero", {if_a.dut_in, if_a.busy,
               if_a.done, if_a.pass, if_a.result_valid, if_a.err_count, if_a.first_fail_vec});
    end
    n_checks++;
    if ({if_b.dut_in, if_b.busy, if_b.done, if_b.pass, if_b.result_valid,
         if_b.err_count, if_b.first_fail_vec} !== 11'd0) begin
      n_errors++;
      $display("FAIL reset_b: outputs=%b required all zero", {if_b.dut_in, if_b.busy,
               if_b.done, if_b.pass, if_b.result_valid, if_b.err_count, if_b.first_fail_vec});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  // One full sweep: expectation pushed at start, popped when done is observed.
  task automatic test_sweep(input bit use_b, input int mode, input string name);
    exp_t        e;
    exp_t        got;
    logic [3:0]  tt;
    logic [1:0]  exp_in;
    int          s;
    int          k;
    bit          seen;
    e.err = 0;
    e.ffv = 0;
    sel_b     = use_b;
    gate_mode = mode;
    s  = use_b ? 3 : 1;
    tt = use_b ? 4'b0110 : 4'b1000;
    for (int v = 0; v < 4; v++) begin
      if (gate_fn(use_b ? 3 : mode, 2'(v)) != tt[v]) begin
        if (e.err == 0) e.ffv = v;
        e.err++;
      end
    end
    e.pass      = (e.err == 0);
    e.done_edge = 4 * (s + 1);
    sb_q.push_back(e);

    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    k = 0;
    seen = 1'b0;
    while (!seen && k <= 200) begin
      if (done_m) begin
        seen = 1'b1;
      end else begin
        exp_in = 2'(k / (s + 1));
        n_checks++;
        if (dut_in_m !== exp_in || busy_m !== 1'b1) begin
          n_errors++;
          $display("FAIL %s_vec edge %0d: dut_in=%0d busy=%b required dut_in=%0d busy=1",
                   name, k, dut_in_m, busy_m, exp_in);
        end
        @(negedge clk);
        k++;
      end
    end
    n_checks++;
    if (!seen) begin
      n_errors++;
      $display("FAIL %s_timeout: no done within %0d edges", name, k);
    end else begin
      got = sb_q.pop_front();
      if (k !== got.done_edge || err_m !== 3'(got.err) || ffv_m !== 2'(got.ffv) ||
          pass_m !== got.pass || rv_m !== 1'b1 || busy_m !== 1'b0) begin
        n_errors++;
        $display("FAIL %s_result: edge=%0d err=%0d ffv=%0d pass=%b rv=%b busy=%b required edge=%0d err=%0d ffv=%0d pass=%b rv=1 busy=0",
                 name, k, err_m, ffv_m, pass_m, rv_m, busy_m,
                 got.done_edge, got.err, got.ffv, got.pass);
      end
    end
    @(negedge clk);
    n_checks++;
    if (done_m !== 1'b0 || rv_m !== 1'b1 || dut_in_m !== 2'd0) begin
      n_errors++;
      $display("FAIL %s_after: done=%b rv=%b dut_in=%0d required done=0 rv=1 dut_in=0",
               name, done_m, rv_m, dut_in_m);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_sweep();
    int ndone;
    sel_b     = 1'b0;
    gate_mode = 1;
    start_a   = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    // now after edge 0; raise reset so it is sampled on edge 5
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (if_a.busy !== 1'b0 || if_a.dut_in !== 2'd0 || if_a.err_count !== 3'd0 ||
        if_a.result_valid !== 1'b0 || if_a.done !== 1'b0 || if_a.first_fail_vec !== 2'd0) begin
      n_errors++;
      $display("FAIL reset_mid: busy=%b dut_in=%0d err=%0d rv=%b done=%b ffv=%0d required all zero",
               if_a.busy, if_a.dut_in, if_a.err_count, if_a.result_valid, if_a.done,
               if_a.first_fail_vec);
    end
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (if_a.done === 1'b1 || if_a.busy === 1'b1) ndone++;
    end
    n_checks++;
    if (ndone != 0) begin
      n_errors++;
      $display("FAIL reset_mid_quiet: active cycles=%0d required 0", ndone);
    end
  endtask

  task automatic test_start_ignored();
    int ndone;
    int done_k;
    sel_b     = 1'b0;
    gate_mode = 1;
    ndone     = 0;
    done_k    = -1;
    start_a   = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 30; k++) begin
      if (if_a.done === 1'b1) begin
        ndone++;
        done_k = k;
      end
      // pulses sampled on edges 3, 8 and 9 (the last one in DONE)
      start_a = (k == 2) || (k == 7) || (k == 8);
      @(negedge clk);
    end
    start_a = 1'b0;
    n_checks++;
    if (ndone != 1 || done_k != 8) begin
      n_errors++;
      $display("FAIL start_ignored: dones=%0d at edge %0d required 1 at edge 8", ndone, done_k);
    end
    n_checks++;
    if (if_a.busy !== 1'b0 || if_a.err_count !== 3'd2 || if_a.result_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL start_ignored_result: busy=%b err=%0d rv=%b required busy=0 err=2 rv=1",
               if_a.busy, if_a.err_count, if_a.result_valid);
    end
  endtask

  task automatic test_back_to_back();
    int  k;
    bit  seen;
    sel_b     = 1'b0;
    gate_mode = 0;
    start_a   = 1'b1;
    @(negedge clk);
    k = 0;
    seen = 1'b0;
    while (!seen && k < 100) begin
      if (if_a.done === 1'b1) seen = 1'b1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    n_checks++;
    if (!seen || k != 8) begin
      n_errors++;
      $display("FAIL hold_first_done: done at edge %0d seen=%b required edge 8", k, seen);
    end
    @(negedge clk);
    n_checks++;
    if (if_a.busy !== 1'b0 || if_a.result_valid !== 1'b1 || if_a.done !== 1'b0) begin
      n_errors++;
      $display("FAIL hold_idle: busy=%b rv=%b done=%b required busy=0 rv=1 done=0",
               if_a.busy, if_a.result_valid, if_a.done);
    end
    @(negedge clk);
    start_a = 1'b0;
    n_checks++;
    if (if_a.busy !== 1'b1 || if_a.result_valid !== 1'b0 || if_a.dut_in !== 2'd0) begin
      n_errors++;
      $display("FAIL hold_restart: busy=%b rv=%b dut_in=%0d required busy=1 rv=0 dut_in=0",
               if_a.busy, if_a.result_valid, if_a.dut_in);
    end
    k = 0;
    seen = 1'b0;
    while (!seen && k < 100) begin
      if (if_a.done === 1'b1) seen = 1'b1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    n_checks++;
    if (!seen || k != 8 || if_a.pass !== 1'b1 || if_a.err_count !== 3'd0) begin
      n_errors++;
      $display("FAIL hold_second: seen=%b edge=%0d pass=%b err=%0d required seen=1 edge=8 pass=1 err=0",
               seen, k, if_a.pass, if_a.err_count);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_sweep(1'b0, 0, "and_ok");
    test_sweep(1'b0, 1, "or_dut");
    test_sweep(1'b1, 3, "xor_settle3");
    test_reset_mid_sweep();
    test_start_ignored();
    test_back_to_back();
    test_sweep(1'b0, 2, "stuck1");
    test_sweep(1'b0, 0, "and_again");
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: %0d entries left required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
